// File: rtl/config_serializer_if.sv
// Bundle between the regfile side and the configuration serializer.
// Slave is the serializer; master supplies config_bits and start.
interface config_serializer_if #(
    parameter int NUMREGS = 16
);
    logic [7:0] config_bits [0:NUMREGS-1];
    logic       start;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       sdata;
    logic       sload;

    modport master (
        output config_bits, start,
        input  busy, done, sclk, sdata, sload
    );

    modport slave (
        input  config_bits, start,
        output busy, done, sclk, sdata, sload
    );
endinterface

// File: rtl/config_serializer.sv
// Snapshots config_bits and shifts it into the analog config chain.
// Optional macro CONFIG_PARITY_EN appends an odd-parity bit per register.
module config_serializer #(
    parameter int NUMREGS = 16,
    parameter int CLKDIV  = 4
) (
    input  logic clk,
    input  logic reset_n,
    config_serializer_if.slave bus
);
`ifdef CONFIG_PARITY_EN
    localparam int BPR = 9;
`else
    localparam int BPR = 8;
`endif
    localparam int POS_W = $clog2(BPR);
    localparam int IDX_W = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMREGS - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BPR - 1);
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLKDIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       shadow [0:NUMREGS-1];
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
    logic [IDX_W-1:0] nxt_idx;
    logic [POS_W-1:0] nxt_pos;
    logic [DIV_W-1:0] div;
    logic             pending;
    logic             busy_q;
    logic             done_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             sload_q;
    logic             last_bit;
    logic             cur_bit;
    logic             nxt_bit;

    // Bit pos within a register, MSB first; pos 8 is the parity slot.
    function automatic logic bit_of(logic [7:0] b, logic [POS_W-1:0] p);
`ifdef CONFIG_PARITY_EN
        if (p == LAST_POS) return ~^b;
`endif
        return b[3'd7 - p[2:0]];
    endfunction

    // Next chain position: registers walk down from NUMREGS-1 to 0.
    always_comb begin
        nxt_pos = pos + 1'b1;
        nxt_idx = idx;
        if (pos == LAST_POS) begin
            nxt_pos = '0;
            nxt_idx = idx - 1'b1;
        end
    end

    assign last_bit = (idx == '0) && (pos == LAST_POS);
    assign cur_bit  = bit_of(shadow[idx], pos);
    assign nxt_bit  = bit_of(shadow[nxt_idx], nxt_pos);

    // Load/shift/latch sequencer with registered chain outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            pos     <= '0;
            div     <= '0;
            pending <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            sload_q <= 1'b0;
            for (int i = 0; i < NUMREGS; i++) shadow[i] <= '0;
        end else begin
            if (bus.start && state != IDLE) pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                        shadow <= bus.config_bits;
                        idx    <= LAST_IDX;
                        pos    <= '0;
                    end
                end
                LOAD: begin
                    div     <= '0;
                    sclk_q  <= 1'b0;
                    sdata_q <= cur_bit;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div == DIV_END) begin
                        div    <= '0;
                        sclk_q <= 1'b1;
                        state  <= SHIFT_HI;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div == DIV_END) begin
                        div    <= '0;
                        sclk_q <= 1'b0;
                        if (last_bit) begin
                            sdata_q <= 1'b0;
                            sload_q <= 1'b1;
                            state   <= LATCH;
                        end else begin
                            idx     <= nxt_idx;
                            pos     <= nxt_pos;
                            sdata_q <= nxt_bit;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                LATCH: begin
                    if (div == DIV_END) begin
                        div     <= '0;
                        sload_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    pending <= 1'b0;
                    if (pending || bus.start) begin
                        state  <= LOAD;
                        shadow <= bus.config_bits;
                        idx    <= LAST_IDX;
                        pos    <= '0;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sclk  = sclk_q;
    assign bus.sdata = sdata_q;
    assign bus.sload = sload_q;
endmodule

// File: tb/tb_config_serializer.sv
// Bench for config_serializer: timeline model plus directed loads.
// Build with CONFIG_PARITY_EN to exercise the parity chain.
module tb_config_serializer;
    localparam int NUMREGS = 16;
    localparam int CLKDIV  = 4;
`ifdef CONFIG_PARITY_EN
    localparam int BPR     = 9;
    localparam int LIT_LAT = 1158;
    localparam int LIT_N   = 144;
    localparam int LIT_T1  = 20;
`else
    localparam int BPR     = 8;
    localparam int LIT_LAT = 1030;
    localparam int LIT_N   = 128;
    localparam int LIT_T1  = 4;
`endif
    localparam int BITS  = NUMREGS * BPR;
    localparam int SHIFT = 2 * CLKDIV * BITS;
    localparam int LAT   = 2 + SHIFT + CLKDIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    config_serializer_if #(.NUMREGS(NUMREGS)) bus ();

    config_serializer #(
        .NUMREGS(NUMREGS),
        .CLKDIV (CLKDIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Model: one load timeline, offset from the cycle start was driven.
    bit   active = 1'b0;
    bit   pending = 1'b0;
    int   start_cyc = 0;
    bit   exp_bits[$];
    bit   got_bits[$];
    logic prev_sclk = 1'b0;
    int   n_done = 0;
    int   done_cyc = 0;
    int   sload_run = 0;
    int   last_sload_run = 0;
    int   o, u;
    logic [4:0] exp_o, act_o;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, got, want);
        end
    endtask

    task automatic build_bits();
        exp_bits.delete();
        for (int r = NUMREGS - 1; r >= 0; r--) begin
            for (int b = 7; b >= 0; b--)
                exp_bits.push_back(bus.config_bits[r][b]);
`ifdef CONFIG_PARITY_EN
            exp_bits.push_back(~^bus.config_bits[r]);
`endif
        end
    endtask

    // Per-cycle compare of {busy,done,sclk,sdata,sload} against the model.
    always @(negedge clk) begin
        exp_o = '0;
        if (active) begin
            o = cyc - start_cyc;
            if (o == 1) begin
                exp_o[4] = 1'b1;
            end else if (o >= 2 && o <= 1 + SHIFT) begin
                u = o - 2;
                exp_o[4] = 1'b1;
                exp_o[2] = (u % (2 * CLKDIV)) >= CLKDIV;
                exp_o[1] = exp_bits[u / (2 * CLKDIV)];
            end else if (o >= 2 + SHIFT && o < LAT) begin
                exp_o[4] = 1'b1;
                exp_o[0] = 1'b1;
            end else if (o == LAT) begin
                exp_o[4] = 1'b1;
                exp_o[3] = 1'b1;
            end
        end
        act_o = {bus.busy, bus.done, bus.sclk, bus.sdata, bus.sload};
        check("busy_done_sclk_sdata_sload", 32'(act_o), 32'(exp_o));

        if (bus.sclk && !prev_sclk) got_bits.push_back(bus.sdata);
        prev_sclk = bus.sclk;
        if (bus.sload) begin
            sload_run++;
        end else begin
            if (sload_run != 0) last_sload_run = sload_run;
            sload_run = 0;
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end

        if (active && (cyc - start_cyc) == LAT) begin
            if (pending) begin
                pending = 1'b0;
                start_cyc = cyc;
                build_bits();
            end else begin
                active = 1'b0;
            end
        end
    end

    task automatic start_pulse(output int t);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        t = cyc;
        if (!active) begin
            active = 1'b1;
            start_cyc = cyc;
            build_bits();
        end else begin
            pending = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(int target, int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_wait", 32'(n_done >= target), 32'd1);
    endtask

    function automatic logic [7:0] got_byte(int first);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) g = {g[6:0], got_bits[first + i]};
        return g;
    endfunction

    function automatic int got_ones();
        int n;
        n = 0;
        foreach (got_bits[i]) n += int'(got_bits[i]);
        return n;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tx, base;
        bus.start = 1'b0;
        for (int i = 0; i < NUMREGS; i++) bus.config_bits[i] = 8'h00;

        // Reset state
        wait_cycles(3);
        check("reset_outputs",
              {27'd0, bus.busy, bus.done, bus.sclk, bus.sdata, bus.sload},
              32'd0);
        reset_n = 1'b1;
        wait_cycles(3);

        // Test 1: reg[15]=A5, others zero
        bus.config_bits[15] = 8'hA5;
        got_bits.delete();
        start_pulse(t0);
        wait_done(1, LAT + 20);
        check("t1_latency", 32'(done_cyc - t0), 32'(LIT_LAT));
        check("t1_first8", 32'(got_byte(0)), 32'hA5);
        check("t1_nbits", 32'(got_bits.size()), 32'(LIT_N));
        check("t1_ones", 32'(got_ones()), 32'(LIT_T1));
        check("t1_sload_len", 32'(last_sload_run), 32'd4);
        wait_cycles(3);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // Test 2: snapshot isolation
        bus.config_bits[15] = 8'h00;
        got_bits.delete();
        start_pulse(t0);
        wait_cycles(10);
        bus.config_bits[0] = 8'hFF;
        wait_done(2, LAT + 20);
        check("t2_old_reg0", 32'(got_byte((NUMREGS - 1) * BPR)), 32'h00);
        wait_cycles(2);
        got_bits.delete();
        start_pulse(t0);
        wait_done(3, LAT + 20);
        check("t2_new_reg0", 32'(got_byte((NUMREGS - 1) * BPR)), 32'hFF);
        wait_cycles(2);

        // Test 3: three starts during busy collapse into one reload
        for (int i = 0; i < NUMREGS; i++)
            bus.config_bits[i] = 8'(i * 37 + 1);
        base = n_done;
        start_pulse(t0);
        wait_cycles(100);
        start_pulse(tx);
        wait_cycles(200);
        start_pulse(tx);
        start_pulse(tx);
        wait_done(base + 2, 2 * LAT + 40);
        check("t3_reload_gap", 32'(done_cyc - t0), 32'(2 * LIT_LAT));
        wait_cycles(2 * LAT / 3);
        check("t3_two_loads", 32'(n_done - base), 32'd2);

        // Test 3b: start landing in the DONE cycle queues a reload
        base = n_done;
        start_pulse(t0);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t0 + LIT_LAT);
        bus.start = 1'b1;
        pending = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(base + 2, LAT + 40);
        check("t3b_reload_gap", 32'(done_cyc - t0), 32'(2 * LIT_LAT));
        wait_cycles(5);

        // Test 4: reset at bit 50, with a reload pending
        base = n_done;
        got_bits.delete();
        start_pulse(t0);
        start_pulse(tx);
        tx = 0;
        while (got_bits.size() < 50 && tx < LAT) begin
            @(posedge clk);
            #1;
            tx++;
        end
        check("t4_reach_bit50", 32'(got_bits.size()), 32'd50);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        active = 1'b0;
        pending = 1'b0;
        #1;
        check("t4_async_clear",
              {27'd0, bus.busy, bus.done, bus.sclk, bus.sdata, bus.sload},
              32'd0);
        wait_cycles(10);
        reset_n = 1'b1;
        wait_cycles(30);
        check("t4_no_done", 32'(n_done - base), 32'd0);
        got_bits.delete();
        start_pulse(t0);
        wait_done(base + 1, LAT + 20);
        check("t4_recover_lat", 32'(done_cyc - t0), 32'(LIT_LAT));
        check("t4_recover_bits", 32'(got_bits.size()), 32'(LIT_N));
        wait_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
